quad_encoder_gen: RTL and testbench

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

---
 rtl/quad_encoder_gen.sv | 124 ++++++++++++
 tb/tb_quad_encoder_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator.
// Emits A/B quadrature edges every step_period clocks in the configured
// direction, tracks position modulo COUNTS_PER_REV and flags the index.
// Configuration is double-buffered: cfg_load fills a shadow copy. The
// shadow moves into the active copy while the generator is idle, or on a
// step edge, so a running interval is never cut short or stretched.
//
// Strobe semantics: cfg_load is a single-cycle request with no
// back-pressure. A load that arrives while cfg_pending=1 replaces the
// shadow, so the latest load wins.
module quad_encoder_gen #(
    parameter int DATA_WIDTH     = 16,
    parameter int COUNTS_PER_REV = 400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfg_load,
    input  logic [DATA_WIDTH-1:0] step_period,
    input  logic                  dir,
    output logic                  cfg_pending,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic                  index,
    output logic [DATA_WIDTH-1:0] position,
    output logic                  step_strobe
);

    localparam logic [DATA_WIDTH-1:0] POS_MAX = DATA_WIDTH'(COUNTS_PER_REV - 1);

    logic [DATA_WIDTH-1:0] per_act;
    logic [DATA_WIDTH-1:0] per_sh;
    logic                  dir_act;
    logic                  dir_sh;
    logic [DATA_WIDTH-1:0] counter;

    logic                  idle;
    logic                  step_now;
    logic                  transfer;
    logic [1:0]            ab_next;
    logic [DATA_WIDTH-1:0] pos_next;

    // Idle/step/transfer decode for the current cycle.
    always_comb begin
        idle     = (enable == 1'b0) || (per_act == '0);
        step_now = !idle && (counter == per_act - DATA_WIDTH'(1));
        transfer = cfg_pending && (idle || step_now);
    end

    // Next quadrature state and position for a step in the active direction.
    // A direction change takes effect from the current {a,b}, so no state
    // is skipped or repeated.
    always_comb begin
        ab_next  = {encoder_a, encoder_b};
        pos_next = position;
        if (dir_act) begin
            case ({encoder_a, encoder_b})
                2'b00:   ab_next = 2'b01;
                2'b01:   ab_next = 2'b11;
                2'b11:   ab_next = 2'b10;
                default: ab_next = 2'b00;
            endcase
            pos_next = (position == POS_MAX) ? '0 : position + DATA_WIDTH'(1);
        end else begin
            case ({encoder_a, encoder_b})
                2'b00:   ab_next = 2'b10;
                2'b10:   ab_next = 2'b11;
                2'b11:   ab_next = 2'b01;
                default: ab_next = 2'b00;
            endcase
            pos_next = (position == '0) ? POS_MAX : position - DATA_WIDTH'(1);
        end
    end

    // Shadow/active configuration registers and the pending flag. When a
    // load coincides with a transfer, the old shadow is transferred and the
    // new data stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_act     <= '0;
            dir_act     <= 1'b1;
            per_sh      <= '0;
            dir_sh      <= 1'b1;
            cfg_pending <= 1'b0;
        end else begin
            if (transfer) begin
                per_act     <= per_sh;
                dir_act     <= dir_sh;
                cfg_pending <= 1'b0;
            end
            if (cfg_load) begin
                per_sh      <= step_period;
                dir_sh      <= dir;
                cfg_pending <= 1'b1;
            end
        end
    end

    // Interval counter plus the registered quadrature outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            encoder_a   <= 1'b0;
            encoder_b   <= 1'b0;
            position    <= '0;
            index       <= 1'b1;
            step_strobe <= 1'b0;
        end else if (idle) begin
            counter     <= '0;
            step_strobe <= 1'b0;
        end else if (step_now) begin
            counter     <= '0;
            encoder_a   <= ab_next[1];
            encoder_b   <= ab_next[0];
            position    <= pos_next;
            index       <= (pos_next == '0) && (ab_next == 2'b00);
            step_strobe <= 1'b1;
        end else begin
            counter     <= transfer ? '0 : counter + DATA_WIDTH'(1);
            step_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: directed configuration sequences. Each
// expected step is queued as {cycle, index, a, b, position}, and a monitor
// pops and compares on every step_strobe.
module tb_quad_encoder_gen;

    localparam int W  = 16;
    localparam int EW = 51;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          cfg_load;
    logic [W-1:0]  step_period;
    logic          dir;
    logic          cfg_pending;
    logic          encoder_a;
    logic          encoder_b;
    logic          index;
    logic [W-1:0]  position;
    logic          step_strobe;

    logic [EW-1:0] exp_q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [1:0]    ab_tab [4];

    quad_encoder_gen #(.DATA_WIDTH(W), .COUNTS_PER_REV(400)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .step_period (step_period),
        .dir         (dir),
        .cfg_pending (cfg_pending),
        .encoder_a   (encoder_a),
        .encoder_b   (encoder_b),
        .index       (index),
        .position    (position),
        .step_strobe (step_strobe)
    );

    // Clock and cycle count (cyc = number of rising edges so far).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog: the whole run is about a thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_step(input int c, input logic idx, input logic ea, input logic eb, input int pos);
        exp_q.push_back({32'(c), idx, ea, eb, 16'(pos)});
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && step_strobe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'(position), 64'hFFFF_FFFF);
            end else begin
                check("step", 64'({32'(cyc), index, encoder_a, encoder_b, position}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    // Driver: cfg_load sampled on edge e (returned); returns at the negedge after e.
    task automatic load(input int p, input logic d, output int e);
        step_period = W'(p);
        dir         = d;
        cfg_load    = 1'b1;
        e           = cyc + 1;
        @(negedge clk);
        cfg_load    = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_state(input string name, input logic ea, input logic eb, input int pos, input logic idx);
        check(name, 64'({encoder_a, encoder_b, index, position}), 64'({ea, eb, idx, 16'(pos)}));
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check_state(name, 1'b0, 1'b0, 0, 1'b1);
        check({name, "_pend"}, 64'({cfg_pending, step_strobe}), 64'(2'b00));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int e0;
        int e;
        int s;
        ab_tab      = '{2'b00, 2'b01, 2'b11, 2'b10};
        reset       = 1'b1;
        enable      = 1'b0;
        cfg_load    = 1'b0;
        step_period = '0;
        dir         = 1'b1;
        repeat (3) @(negedge clk);
        check_state("reset_state", 1'b0, 1'b0, 0, 1'b1);
        check("reset_pend", 64'({cfg_pending, step_strobe}), 64'(2'b00));
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check_state("idle_hold", 1'b0, 1'b0, 0, 1'b1);

        // Start from idle, P=4 forward: steps at e0+5, +9, +13, +17.
        load(4, 1'b1, e0);
        check("pend_set", 64'(cfg_pending), 64'(1));
        push_step(e0 + 5,  1'b0, 1'b0, 1'b1, 1);
        push_step(e0 + 9,  1'b0, 1'b1, 1'b1, 2);
        push_step(e0 + 13, 1'b0, 1'b1, 1'b0, 3);
        push_step(e0 + 17, 1'b0, 1'b0, 1'b0, 4);
        @(negedge clk);
        check("pend_clr_idle", 64'(cfg_pending), 64'(0));
        wait_to(e0 + 13);
        load(0, 1'b1, e);
        wait_to(e0 + 24);
        check_state("stop_a", 1'b0, 1'b0, 4, 1'b0);
        check("drain_a", 64'(exp_q.size()), 64'(0));

        // Reverse from reset, P=2: first step wraps position to 399.
        do_reset("reset_b");
        load(2, 1'b0, e0);
        push_step(e0 + 3, 1'b0, 1'b1, 1'b0, 399);
        push_step(e0 + 5, 1'b0, 1'b1, 1'b1, 398);
        wait_to(e0 + 3);
        load(0, 1'b0, e);
        wait_to(e0 + 9);
        check_state("stop_b", 1'b1, 1'b1, 398, 1'b0);

        // Period change while running: P=10, then P=3 loaded 4 cycles after a step.
        do_reset("reset_c");
        load(10, 1'b1, e0);
        s = e0 + 11;
        push_step(s, 1'b0, 1'b0, 1'b1, 1);
        wait_to(s + 3);
        load(3, 1'b1, e);
        check("pend_run", 64'(cfg_pending), 64'(1));
        push_step(s + 10, 1'b0, 1'b1, 1'b1, 2);
        push_step(s + 13, 1'b0, 1'b1, 1'b0, 3);
        push_step(s + 16, 1'b0, 1'b0, 1'b0, 4);
        wait_to(s + 9);
        check("pend_hold", 64'(cfg_pending), 64'(1));
        wait_to(s + 10);
        check("pend_clr_step", 64'(cfg_pending), 64'(0));
        wait_to(s + 18);
        check_state("mid_run_c", 1'b0, 1'b0, 4, 1'b0);
        do_reset("reset_mid_run");
        repeat (5) @(negedge clk);
        check_state("after_reset_c", 1'b0, 1'b0, 0, 1'b1);

        // Freeze with enable=0 mid-interval, then reverse direction.
        load(5, 1'b1, e0);
        s = e0 + 11;
        push_step(e0 + 6, 1'b0, 1'b0, 1'b1, 1);
        push_step(s,      1'b0, 1'b1, 1'b1, 2);
        wait_to(s + 1);
        enable = 1'b0;
        wait_to(s + 11);
        check_state("frozen", 1'b1, 1'b1, 2, 1'b0);
        wait_to(s + 21);
        enable = 1'b1;
        push_step(s + 26, 1'b0, 1'b1, 1'b0, 3);
        wait_to(s + 26);
        load(2, 1'b0, e);
        push_step(s + 31, 1'b0, 1'b0, 1'b0, 4);
        push_step(s + 33, 1'b0, 1'b1, 1'b0, 3);
        push_step(s + 35, 1'b0, 1'b1, 1'b1, 2);
        wait_to(s + 33);
        load(0, 1'b0, e);
        wait_to(s + 40);
        check_state("stop_dir", 1'b1, 1'b1, 2, 1'b0);

        // Full revolution at P=1: 400 steps, index only on the last one.
        do_reset("reset_e");
        load(1, 1'b1, e0);
        for (int k = 1; k <= 400; k++) begin
            push_step(e0 + 1 + k, (k == 400), ab_tab[k % 4][1], ab_tab[k % 4][0], k % 400);
        end
        wait_to(e0 + 399);
        load(0, 1'b1, e);
        wait_to(e0 + 406);
        check_state("rev_end", 1'b0, 1'b0, 0, 1'b1);

        check("drain_final", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
